// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer.
//   sb_entry_t  : one buffered word store (valid bit, word address, data)
//   sb_state_t  : drain FSM state encoding (IDLE / ISSUE)
//   word_match  : word-granular address compare (byte offset already dropped)
package sb_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic                   valid;
        logic [SB_ADDR_W-1:2]   waddr;
        logic [SB_DATA_W-1:0]   data;
    } sb_entry_t;

    typedef logic [0:0] sb_state_t;
    localparam sb_state_t IDLE  = 1'b0;
    localparam sb_state_t ISSUE = 1'b1;

    function automatic logic word_match(input logic [SB_ADDR_W-1:2] a,
                                        input logic [SB_ADDR_W-1:2] b);
        return a == b;
    endfunction

endpackage

// File: rtl/sb_forward_lookup.sv
// Youngest-match search over the store buffer entry ring.
// Walks the occupied slots from head (oldest) to head+count-1 (youngest);
// the last valid match wins, so the result is the youngest matching store.
//   entries    : whole entry array, index = ring slot
//   head/count : occupied window of the ring
//   probe_waddr: word address being looked up
//   mask_head  : ignore the head slot (used while the head is being issued)
//   hit/idx/data : match found, its slot, and its data (0 when no hit)
module sb_forward_lookup
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0]   entries,
    input  logic [PTR_W-1:0]        head,
    input  logic [PTR_W:0]          count,
    input  logic [SB_ADDR_W-1:2]    probe_waddr,
    input  logic                    mask_head,
    output logic                    hit,
    output logic [PTR_W-1:0]        idx,
    output logic [SB_DATA_W-1:0]    data
);

    logic [PTR_W-1:0] pos;

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        data = '0;
        pos  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = head + PTR_W'(k);
            if ((PTR_W+1)'(k) < count && !(mask_head && k == 0) &&
                entries[pos].valid && word_match(entries[pos].waddr, probe_waddr)) begin
                hit  = 1'b1;
                idx  = pos;
                data = entries[pos].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Write-coalescing store buffer between commit and the data cache.
// Committed word stores are queued (or merged into an existing entry for the
// same word) and drained to the cache whenever the cache and the load port
// are free. Loads get combinational forwarding from the youngest match.
//
// Ports:
//   clk, reset (async, active-low)
//   st_valid/st_addr/st_data/st_ready : store push
//   ld_valid/ld_addr -> ld_hit/ld_data : forwarding probe
//   ld_cache_req, dc_busy : drain inhibits
//   dc_done               : cache accepted the current write
//   dc_write/dc_address/dc_writedata : write request to the cache
//   count/empty           : occupancy
//   dbg_state             : drain FSM state
//
// Handshake: a store transfers on any clock edge where st_valid && st_ready;
// st_ready depends only on registered occupancy, never on st_valid. On the
// cache side a write is outstanding while dc_write is high; address/data stay
// fixed until the cycle dc_done is seen, and are never withdrawn early.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        st_valid,
    input  logic [ADDR_W-1:0]           st_addr,
    input  logic [DATA_W-1:0]           st_data,
    output logic                        st_ready,
    input  logic                        ld_valid,
    input  logic [ADDR_W-1:0]           ld_addr,
    output logic                        ld_hit,
    output logic [DATA_W-1:0]           ld_data,
    input  logic                        ld_cache_req,
    input  logic                        dc_busy,
    input  logic                        dc_done,
    output logic                        dc_write,
    output logic [ADDR_W-1:0]           dc_address,
    output logic [DATA_W-1:0]           dc_writedata,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty,
    output sb_state_t                   dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t [DEPTH-1:0]  entries;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    sb_state_t              state;
    sb_state_t              state_next;
    logic [CNT_W-1:0]       count_next;

    logic                   push;
    logic                   pop;
    logic                   alloc;

    logic                   mrg_hit;
    logic [PTR_W-1:0]       mrg_idx;
    logic [DATA_W-1:0]      mrg_data;

    logic                   fwd_hit;
    logic [PTR_W-1:0]       fwd_idx;
    logic [DATA_W-1:0]      fwd_data;

    // Byte offsets never participate in word matching.
    logic                   unused_bits;
    assign unused_bits = ^{st_addr[1:0], ld_addr[1:0], mrg_data, fwd_idx};

    // Merge search: the head is masked while it is being issued so the data
    // the cache sees cannot change under it; such a store allocates instead.
    sb_forward_lookup #(.DEPTH(DEPTH)) u_merge_lookup (
        .entries     (entries),
        .head        (head),
        .count       (count),
        .probe_waddr (st_addr[ADDR_W-1:2]),
        .mask_head   (state == ISSUE),
        .hit         (mrg_hit),
        .idx         (mrg_idx),
        .data        (mrg_data)
    );

    sb_forward_lookup #(.DEPTH(DEPTH)) u_fwd_lookup (
        .entries     (entries),
        .head        (head),
        .count       (count),
        .probe_waddr (ld_addr[ADDR_W-1:2]),
        .mask_head   (1'b0),
        .hit         (fwd_hit),
        .idx         (fwd_idx),
        .data        (fwd_data)
    );

    assign st_ready = (count < CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push     = st_valid && st_ready;
    assign alloc    = push && !mrg_hit;
    assign pop      = (state == ISSUE) && dc_done;

    assign count_next = count + CNT_W'(alloc) - CNT_W'(pop);

    assign ld_hit  = ld_valid && fwd_hit;
    assign ld_data = ld_hit ? fwd_data : '0;

    // Write request is a straight decode of the state flop; the head entry
    // cannot be modified while issuing, so address/data are stable.
    assign dc_write     = (state == ISSUE);
    assign dc_address   = dc_write ? {entries[head].waddr, 2'b00} : '0;
    assign dc_writedata = dc_write ? entries[head].data : '0;
    assign dbg_state    = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count != '0 && !ld_cache_req && !dc_busy)
                    state_next = ISSUE;
            end
            ISSUE: begin
                // Keep issuing back-to-back only if something remains behind
                // the entry being popped and nothing inhibits the drain.
                if (dc_done) begin
                    if (count > CNT_W'(1) && !ld_cache_req && !dc_busy)
                        state_next = ISSUE;
                    else
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            state   <= IDLE;
        end else begin
            // Pop and allocate never touch the same slot: pop needs count>0,
            // allocate needs count<DEPTH, so tail != head whenever both fire.
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            if (push) begin
                if (mrg_hit) begin
                    entries[mrg_idx].data <= st_data;
                end else begin
                    entries[tail] <= '{valid: 1'b1,
                                       waddr: st_addr[ADDR_W-1:2],
                                       data:  st_data};
                    tail          <= tail + PTR_W'(1);
                end
            end
            count <= count_next;
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            assert (count <= CNT_W'(DEPTH));
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-coalescing FIFO between the MEM/commit stage and data_cache. It holds committed word stores and drains them into the cache when the cache is idle.
- Loads probe it combinationally and get store-to-load forwarding from the youngest matching entry.
- Pipeline stores never stall on cache misses unless the buffer is full.

Parameters:
- DEPTH, 4, number of entries (power of two, >=2)
- ADDR_W, 32, byte address width
- DATA_W, 32, store data width (word stores only)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- st_valid  in  1  committed store request
- st_addr  in  ADDR_W  store byte address (bits [1:0] ignored)
- st_data  in  DATA_W  store data
- st_ready  out  1  buffer can accept a store this cycle
- ld_valid  in  1  load probe
- ld_addr  in  ADDR_W  load byte address
- ld_hit  out  1  forwarding hit (combinational)
- ld_data  out  DATA_W  forwarded data (combinational)
- ld_cache_req  in  1  pipeline needs the cache for a read this cycle
- dc_busy  in  1  cache has a miss/writeback outstanding
- dc_done  in  1  cache accepted the current write (1-cycle pulse)
- dc_write  out  1  write request to data_cache
- dc_address  out  ADDR_W  write address, word-aligned
- dc_writedata  out  DATA_W  write data
- count  out  $clog2(DEPTH)+1  valid entries
- empty  out  1  count==0

Behaviour:
- Reset (reset==0, async):
  - All entries invalid; head/tail/count = 0.
  - dc_write = 0, dc_address = 0, dc_writedata = 0, st_ready = 1, empty = 1.
  - FSM goes to IDLE.
  - A store in flight is discarded; no partial state survives.
- Word match rule: compare addr[ADDR_W-1:2] only.
- Push (st_valid && st_ready):
  - If a valid entry matches and it is not the head while the FSM is in ISSUE, overwrite that entry's data in place. Count is unchanged.
  - Otherwise allocate at tail; tail wraps modulo DEPTH; count+1.
  - With DEPTH>=2, at most one non-issuing match can exist.
- st_ready = (count < DEPTH), from registered count. A simultaneous pop does not raise st_ready in the same cycle.
- Forwarding:
  - ld_hit = ld_valid && any valid entry matches ld_addr.
  - ld_data = data of the youngest match (the entry nearest tail-1), else 0.
  - A store pushed in the current cycle is not visible until the next cycle.
- Drain FSM:
  - IDLE → ISSUE when count>0 && !ld_cache_req && !dc_busy. dc_write asserts on the following cycle with head addr/data.
  - ISSUE: dc_write=1; dc_address/dc_writedata are held stable from head and never withdrawn, even if ld_cache_req rises.
  - On dc_done: pop head (head wraps, count-1).
  - After dc_done, stay in ISSUE if count-1>0 && !ld_cache_req && !dc_busy. This gives back-to-back drain, 1 write per cycle at best. Otherwise go to IDLE with dc_write=0.
  - dc_done while in IDLE is ignored.
- Simultaneous push and pop: count unchanged. A push into an empty buffer cannot be popped in the same cycle.
- Push-merge into an entry while another entry is popped is allowed.
- Full buffer with st_valid: the store is not accepted; the producer holds it.
- Counts and pointers are unsigned; no overflow is possible by construction (assert count<=DEPTH).

Decomposition:
- sb_pkg:
  - sb_entry_t {valid, waddr[ADDR_W-1:2], data}
  - sb_state_t {IDLE, ISSUE}
  - function word_match(a,b)
- Sub-module sb_forward_lookup: combinational youngest-match priority search over the entry array given head/count. It is reused by the merge search with the issuing head masked off.

Test Plan:
- Basic drain: push 0x100←0xAAAA0001, dc_busy=0 → dc_write rises 2 cycles after push with dc_address=0x100, dc_writedata=0xAAAA0001; dc_done → count 0, empty=1.
- Fill/backpressure with dc_busy=1: push 4 distinct stores → st_ready=0 after the 4th; a 5th held store is not accepted. Release dc_busy and pulse dc_done ×4 → drained in FIFO order, st_ready returns 1 one cycle after the first pop.
- Merge and forward: push 0x200←0x11, 0x204←0x22, then 0x202←0x33 → count stays 2; ld probe 0x200 → ld_hit=1, ld_data=0x33; ld probe 0x208 → ld_hit=0, ld_data=0.
- No merge into issuing head: head 0x300 in ISSUE, push 0x300←0x55 → new entry, count 2. Probe 0x300 → 0x55. Drain order: old data, then 0x55.
- Load priority: count=2, ld_cache_req=1 held → dc_write stays 0. Raise ld_cache_req mid-ISSUE → dc_write stays 1 until dc_done, then drops.
- Async reset mid-ISSUE with count=3: assert reset low between clock edges → dc_write=0, count=0, st_ready=1 immediately. dc_done after release is ignored.
